// File: rtl/key_highlight_sched.sv
// Piano key highlight scheduler for the LCD overlay.
// Arbitrates key strikes from the keypad (port 0) and the playback sequencer (port 1) round-robin,
// holds at most one pending note, and applies it only at frame start so that no frame is drawn
// with a torn key. Each highlight stays lit for HOLD_FRAMES frames.
//
// Ports:
//   clk_lcd, rst_n          pixel clock, asynchronous active-low reset
//   hcount_reg, Vcount_reg  raster position from the LCD timing generator
//   req0/note0/ack0         keypad request, note and one-cycle accept pulse
//   req1/note1/ack1         sequencer request, note and one-cycle accept pulse
//   offset                  key rectangle x-offset (note * KEY_W)
//   rgb_en                  display output enable
//   busy                    a note is pending or a highlight is shown
//   bad_note                pulses with an ack whose note is out of range
module key_highlight_sched #(
  parameter int unsigned NUM_KEYS    = 8,
  parameter int unsigned KEY_W       = 58,
  parameter int unsigned NOTE_W      = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic              clk_lcd,
  input  logic              rst_n,
  input  logic [9:0]        hcount_reg,
  input  logic [8:0]        Vcount_reg,
  input  logic              req0,
  input  logic [NOTE_W-1:0] note0,
  output logic              ack0,
  input  logic              req1,
  input  logic [NOTE_W-1:0] note1,
  output logic              ack1,
  output logic [9:0]        offset,
  output logic              rgb_en,
  output logic              busy,
  output logic              bad_note
);

  localparam int unsigned     CntW    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_FRAMES - 1);
  localparam logic [9:0]      KeyW    = 10'(KEY_W);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [9:0]        offset_q, offset_d;
  logic              rgb_en_q, rgb_en_d;
  logic              pend_valid_q, pend_valid_d;
  logic [NOTE_W-1:0] pend_note_q, pend_note_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              bad_q, bad_d, busy_q, busy_d;
  logic              last1_q, last1_d;  // 1: port 1 was granted last, so port 0 is favoured
  logic              zero_q, tick_q;

  logic              zero_cmp, free, elig0, elig1, grant0, grant1, gbad;
  logic [NOTE_W-1:0] gnote;

  assign zero_cmp = (hcount_reg == 10'd0) && (Vcount_reg == 9'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    offset_d     = offset_q;
    rgb_en_d     = rgb_en_q;
    pend_valid_d = pend_valid_q;
    pend_note_d  = pend_note_q;
    last1_d      = last1_q;

    // A tick frees the pending slot in the same edge, so a new note can land there without loss.
    free  = !pend_valid_q || tick_q;
    // A request still high while its ack is visible is the old request, not a new one.
    elig0 = req0 && !ack0_q;
    elig1 = req1 && !ack1_q;
    grant0 = free && elig0 && (!elig1 || last1_q);
    grant1 = free && elig1 && !grant0;
    gnote  = grant1 ? note1 : note0;
    gbad   = (grant0 || grant1) && (32'(gnote) >= NUM_KEYS);

    if (tick_q) begin
      if (pend_valid_q) begin
        offset_d     = 10'(pend_note_q) * KeyW;
        rgb_en_d     = 1'b1;
        cnt_d        = CntLoad;
        pend_valid_d = 1'b0;
        state_d      = StShow;
      end else if (state_q == StShow) begin
        if (cnt_q == '0) begin
          rgb_en_d = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    if ((grant0 || grant1) && !gbad) begin
      pend_valid_d = 1'b1;
      pend_note_d  = gnote;
    end
    if (grant0) last1_d = 1'b0;
    if (grant1) last1_d = 1'b1;

    ack0_d = grant0;
    ack1_d = grant1;
    bad_d  = gbad;
    busy_d = pend_valid_d || (state_d == StShow);
  end

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      offset_q     <= '0;
      rgb_en_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_note_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      bad_q        <= 1'b0;
      busy_q       <= 1'b0;
      last1_q      <= 1'b1;
      zero_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      offset_q     <= offset_d;
      rgb_en_q     <= rgb_en_d;
      pend_valid_q <= pend_valid_d;
      pend_note_q  <= pend_note_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      bad_q        <= bad_d;
      busy_q       <= busy_d;
      last1_q      <= last1_d;
      zero_q       <= zero_cmp;
      // Rising edge of the zero compare: one tick however long the counters sit at zero.
      tick_q       <= zero_cmp && !zero_q;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign offset   = offset_q;
  assign rgb_en   = rgb_en_q;
  assign busy     = busy_q;
  assign bad_note = bad_q;

endmodule

// File: tb/tb_key_highlight_sched.sv
module tb_key_highlight_sched;

  localparam int NUM_KEYS = 8;
  localparam int KEY_W    = 58;
  localparam int NOTE_W   = 4;
  localparam int HOLD     = 2;

  logic              clk_lcd = 1'b0;
  logic              rst_n;
  logic [9:0]        hcount_reg;
  logic [8:0]        Vcount_reg;
  logic              req0, req1;
  logic [NOTE_W-1:0] note0, note1;
  logic              ack0, ack1, rgb_en, busy, bad_note;
  logic [9:0]        offset;

  int checks = 0;
  int errors = 0;

  always #5 clk_lcd = ~clk_lcd;

  key_highlight_sched #(
    .NUM_KEYS(NUM_KEYS), .KEY_W(KEY_W), .NOTE_W(NOTE_W), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk_lcd(clk_lcd), .rst_n(rst_n), .hcount_reg(hcount_reg), .Vcount_reg(Vcount_reg),
    .req0(req0), .note0(note0), .ack0(ack0), .req1(req1), .note1(note1), .ack1(ack1),
    .offset(offset), .rgb_en(rgb_en), .busy(busy), .bad_note(bad_note)
  );

  // Reference model: a one-deep pending queue, the lit note and the frames it has left.
  int m_pend[$];
  bit m_lit;
  int m_left;
  int m_off;
  int m_last;   // port granted most recently
  bit m_tick;   // frame start seen by the controller during the current cycle
  bit m_zprev;
  bit e_ack0, e_ack1, e_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_lit = 0; m_left = 0; m_off = 0; m_last = 1;
    m_tick = 0; m_zprev = 0;
    e_ack0 = 0; e_ack1 = 0; e_bad = 0;
  endtask

  // Predict the coming edge from the inputs now driven, advance one clock, then compare.
  task automatic step();
    bit zero_now, free, el0, el1, g0, g1;
    int note;
    zero_now = (hcount_reg == 0) && (Vcount_reg == 0);
    free = (m_pend.size() == 0) || m_tick;
    if (m_tick) begin
      if (m_pend.size() > 0) begin
        m_off  = m_pend.pop_front() * KEY_W;
        m_lit  = 1;
        m_left = HOLD;
      end else if (m_lit) begin
        m_left--;
        if (m_left == 0) m_lit = 0;
      end
    end
    el0 = req0 && !e_ack0;
    el1 = req1 && !e_ack1;
    g0 = 0; g1 = 0;
    if (free) begin
      if (el0 && el1) begin
        if (m_last == 1) g0 = 1; else g1 = 1;
      end else begin
        g0 = el0; g1 = el1;
      end
    end
    note   = g1 ? int'(note1) : int'(note0);
    e_ack0 = g0;
    e_ack1 = g1;
    e_bad  = (g0 || g1) && (note >= NUM_KEYS);
    if ((g0 || g1) && !e_bad) m_pend.push_back(note);
    if (g0) m_last = 0;
    if (g1) m_last = 1;
    m_tick  = zero_now && !m_zprev;
    m_zprev = zero_now;

    @(negedge clk_lcd);
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("bad_note", 32'(bad_note), 32'(e_bad));
    chk("offset", 32'(offset), 32'(m_off));
    chk("rgb_en", 32'(rgb_en), 32'(m_lit));
    chk("busy", 32'(busy), 32'((m_pend.size() > 0) || m_lit));
    // Requesters drop their line once they see the accept.
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Frame start: counters sit at zero for z cycles, then move on; outputs settle before return.
  task automatic frame(input int z);
    hcount_reg = 10'd0;
    Vcount_reg = 9'd0;
    for (int i = 0; i < z; i++) step();
    hcount_reg = 10'd37;
    Vcount_reg = 9'd12;
    idle_steps(3);
  endtask

  task automatic strike(input int port, input int note);
    if (port == 0) begin req0 = 1'b1; note0 = NOTE_W'(note); end
    else           begin req1 = 1'b1; note1 = NOTE_W'(note); end
  endtask

  logic [9:0] sv_off;
  logic       sv_rgb, sv_busy;
  int         fcnt, zleft;

  initial begin
    rst_n = 1'b0;
    hcount_reg = 10'd37; Vcount_reg = 9'd12;
    req0 = 1'b1; note0 = 4'd3; req1 = 1'b0; note1 = 4'd0;
    model_reset();

    // Reset holds everything low even with a request present.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_lcd);
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_outs", 32'({offset, rgb_en, busy, bad_note, ack1}), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("release_ack0", 32'(ack0), 32'd1);

    // Single strike of note 3: lit at next frame, held two frames, offset kept after.
    idle_steps(4);
    frame(1);
    chk("single_off", 32'(offset), 32'd174);
    chk("single_rgb", 32'(rgb_en), 32'd1);
    frame(2);
    chk("single_rgb_hold", 32'(rgb_en), 32'd1);
    frame(3);
    chk("single_rgb_off", 32'(rgb_en), 32'd0);
    chk("single_off_kept", 32'(offset), 32'd174);

    // Retrigger: note 2 lit, note 7 accepted in SHOW restarts the hold.
    strike(1, 2);
    idle_steps(3);
    frame(1);
    chk("retrig_first", 32'(offset), 32'd116);
    strike(0, 7);
    idle_steps(3);
    frame(2);
    chk("retrig_off", 32'(offset), 32'd406);
    frame(1);
    chk("retrig_hold", 32'(rgb_en), 32'd1);
    frame(1);
    chk("retrig_end", 32'(rgb_en), 32'd0);

    // Illegal note: acked with bad_note, visible state untouched.
    sv_off = offset; sv_rgb = rgb_en; sv_busy = busy;
    strike(1, 9);
    step();
    chk("illegal_ack1", 32'(ack1), 32'd1);
    chk("illegal_bad", 32'(bad_note), 32'd1);
    idle_steps(2);
    chk("illegal_keep", 32'({offset, rgb_en, busy}), 32'({sv_off, sv_rgb, sv_busy}));

    // Contention: port 0 wins, port 1 waits for the tick to free the slot.
    strike(0, 1);
    strike(1, 5);
    step();
    chk("cont_ack0_first", 32'({ack0, ack1}), 32'b10);
    idle_steps(4);
    chk("cont_ack1_held", 32'(req1), 32'd1);
    frame(1);
    chk("cont_off1", 32'(offset), 32'd58);
    chk("cont_req1_done", 32'(req1), 32'd0);
    frame(2);
    chk("cont_off2", 32'(offset), 32'd290);

    // Reset mid-SHOW clears outputs at once, without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({offset, rgb_en, busy}), 32'd0);
    model_reset();
    @(negedge clk_lcd);
    rst_n = 1'b1;
    idle_steps(2);
    frame(1);
    frame(1);
    chk("midrst_dark", 32'(rgb_en), 32'd0);

    // Randomised traffic with notes including out-of-range values and multi-cycle frame starts.
    fcnt = 10; zleft = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!req0 && $urandom_range(0, 9) == 0) strike(0, int'($urandom_range(0, 9)));
      if (!req1 && $urandom_range(0, 9) == 0) strike(1, int'($urandom_range(0, 9)));
      if (zleft > 0) begin
        zleft--;
        if (zleft == 0) begin hcount_reg = 10'd1; Vcount_reg = 9'd0; end
      end else if (fcnt == 0) begin
        hcount_reg = 10'd0; Vcount_reg = 9'd0;
        zleft = int'($urandom_range(1, 3));
        fcnt = int'($urandom_range(5, 40));
      end else begin
        fcnt--;
        hcount_reg = 10'($urandom_range(1, 799));
        Vcount_reg = 9'($urandom_range(0, 479));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
